// File: rtl/mc_pkg.sv
// Shared constants and helpers for the Monte-Carlo peak tally block.
// Frame geometry, sample and magnitude widths, FSM encodings.
package mc_pkg;

  localparam int FRAME_LEN = 256;
  localparam int BIN_W     = 8;
  localparam int SAMP_W    = 16;
  localparam int MAG_W     = 32;
  localparam int SQ_W      = 31;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Two squares of at most 2^30 each: the sum peaks at 2^31 and cannot overflow.
  function automatic logic [MAG_W-1:0] mag_sum(input logic [SQ_W-1:0] a,
                                               input logic [SQ_W-1:0] b);
    return MAG_W'(a) + MAG_W'(b);
  endfunction

endpackage

// File: rtl/mc_mag2.sv
// Two-stage registered |y|^2 unit: S1 squares each part, S2 sums them.
// The bin index and a valid bit travel alongside so the compare stage sees aligned beats.
module mc_mag2
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [SAMP_W-1:0] y_real,
  input  logic [SAMP_W-1:0] y_img,
  input  logic [BIN_W-1:0]  in_bin,
  output logic              out_valid,
  output logic [BIN_W-1:0]  out_bin,
  output logic [MAG_W-1:0]  mag
);

  logic [SQ_W-1:0]  sq_re;
  logic [SQ_W-1:0]  sq_im;
  logic [SQ_W-1:0]  s1_re;
  logic [SQ_W-1:0]  s1_im;
  logic             s1_valid;
  logic [BIN_W-1:0] s1_bin;

  // A signed square is never negative and (-32768)^2 = 2^30 fits in 31 bits.
  assign sq_re = SQ_W'($signed(y_real) * $signed(y_real));
  assign sq_im = SQ_W'($signed(y_img) * $signed(y_img));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      s1_bin    <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      mag       <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_re  <= sq_re;
        s1_im  <= sq_im;
        s1_bin <= in_bin;
      end
      if (s1_valid) begin
        out_bin <= s1_bin;
        mag     <= mag_sum(s1_re, s1_im);
      end
    end
  end

endmodule

// File: rtl/mc_peak_tally.sv
// Per-frame |y|^2 peak search over 256 bins with detection flag and run-level hit tally.
// Handshake: a sample is taken on any cycle with in_valid high while in RUN and no start; there is no ready.
module mc_peak_tally
  import mc_pkg::*;
#(
  parameter int NUM_TRIALS = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAG_W-1:0]  threshold,
  input  logic [BIN_W-1:0]  target_idx,
  input  logic              in_valid,
  input  logic [SAMP_W-1:0] y_real,
  input  logic [SAMP_W-1:0] y_img,
  output logic              peak_valid,
  output logic [BIN_W-1:0]  peak_idx,
  output logic [MAG_W-1:0]  peak_mag,
  output logic              hit,
  output logic [CNT_W-1:0]  trial_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              busy,
  output logic              done
);

  logic [1:0]       state;
  logic [MAG_W-1:0] thr_q;
  logic [BIN_W-1:0] tgt_q;
  logic [BIN_W-1:0] bin_q;
  logic             acc;
  logic             s2_valid;
  logic [BIN_W-1:0] s2_bin;
  logic [MAG_W-1:0] s2_mag;
  logic [MAG_W-1:0] max_mag;
  logic [BIN_W-1:0] max_idx;
  logic             hit_now;
  logic             last_trial;

  assign acc        = (state == ST_RUN) && in_valid && !start;
  assign hit_now    = (max_mag >= thr_q) && (max_idx == tgt_q);
  assign last_trial = (({1'b0, trial_cnt} + 1'b1) == (CNT_W+1)'(NUM_TRIALS));

  // The final peak_valid still counts as busy; done follows one cycle later.
  assign busy = (state == ST_RUN) || (state == ST_REPORT) ||
                ((state == ST_DONE) && peak_valid);
  assign done = (state == ST_DONE) && !peak_valid;

  mc_mag2 u_mag2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .in_valid  (acc),
    .y_real    (y_real),
    .y_img     (y_img),
    .in_bin    (bin_q),
    .out_valid (s2_valid),
    .out_bin   (s2_bin),
    .mag       (s2_mag)
  );

  // Running max: bin 0 reloads, later bins only win when strictly larger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_mag <= '0;
      max_idx <= '0;
    end else if (start) begin
      max_mag <= '0;
      max_idx <= '0;
    end else if (s2_valid && ((s2_bin == '0) || (s2_mag > max_mag))) begin
      max_mag <= s2_mag;
      max_idx <= s2_bin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      thr_q      <= '0;
      tgt_q      <= '0;
      bin_q      <= '0;
      peak_valid <= 1'b0;
      peak_idx   <= '0;
      peak_mag   <= '0;
      hit        <= 1'b0;
      trial_cnt  <= '0;
      hit_cnt    <= '0;
    end else if (start) begin
      state      <= ST_RUN;
      thr_q      <= threshold;
      tgt_q      <= target_idx;
      bin_q      <= '0;
      peak_valid <= 1'b0;
      peak_idx   <= '0;
      peak_mag   <= '0;
      hit        <= 1'b0;
      trial_cnt  <= '0;
      hit_cnt    <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (acc) bin_q <= bin_q + 1'b1;
      case (state)
        ST_RUN: begin
          if (s2_valid && (s2_bin == LAST_BIN)) state <= ST_REPORT;
        end
        ST_REPORT: begin
          peak_valid <= 1'b1;
          peak_idx   <= max_idx;
          peak_mag   <= max_mag;
          hit        <= hit_now;
          trial_cnt  <= trial_cnt + 1'b1;
          if (hit_now && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
          state      <= last_trial ? ST_DONE : ST_RUN;
        end
        default: state <= state;
      endcase
    end
  end

endmodule
